// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: CORDIC operation sequencer (load, ITER steps, optional scale, held result-valid).
// Define CORDIC_SCALE_EN to insert the one-cycle SCALE state with its scl strobe.
module cordic_iter_ctrl #(
  parameter int ITER  = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             clr,
  input  logic             d,
  input  logic             dn,
  input  logic             ack,
  output logic             busy,
  output logic             ld,
  output logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             v,
  output logic             valid,
  output logic             err,
  output logic             scl
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
`ifdef CORDIC_SCALE_EN
    S_SCALE,
`endif
    S_DONE
  } state_t;
  state_t state, nxt;
  logic accept, last;
  assign accept = state == S_IDLE && start && !clr;
  assign last   = idx == IDX_W'(ITER - 1);
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = accept ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = S_ITER;
`ifdef CORDIC_SCALE_EN
      S_ITER:  nxt = last ? S_SCALE : S_ITER;
      S_SCALE: nxt = S_DONE;
`else
      S_ITER:  nxt = last ? S_DONE : S_ITER;
`endif
      S_DONE:  nxt = ack ? S_IDLE : S_DONE;
      default: nxt = S_IDLE;
    endcase
    if (clr) nxt = S_IDLE;
  end
  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      ld    <= 1'b0;
      en    <= 1'b0;
      valid <= 1'b0;
      idx   <= '0;
      v     <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      busy  <= nxt != S_IDLE;
      ld    <= nxt == S_LOAD;
      en    <= nxt == S_ITER;
      valid <= nxt == S_DONE;
      idx   <= (state == S_ITER && nxt == S_ITER) ? idx + 1'b1 : '0;
      if (accept) begin
        v   <= mode;
        err <= 1'b0;
      end else if (en && d == dn) begin
        err <= 1'b1;
      end
    end
  end
`ifdef CORDIC_SCALE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scl <= 1'b0;
    else scl <= nxt == S_SCALE;
  end
`else
  assign scl = 1'b0;
`endif
endmodule
